// File: rtl/psx_ddr_avalon_responder_if.sv
// Avalon-MM bus between the GPU memory bridge (master) and the DDR stand-in
// responder (slave): 64-bit data, word addressing, pipelined reads.
interface psx_ddr_avalon_responder_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] i_targetAddr;
  logic [2:0]        i_burstLength;
  logic              i_readEnableMem;
  logic              i_writeEnableMem;
  logic [63:0]       i_dataMem;
  logic [7:0]        i_byteEnableMem;
  logic              o_busyMem;
  logic              o_dataValidMem;
  logic [63:0]       o_dataMem;
  logic              o_protocolError;

  modport master (
    output i_targetAddr, i_burstLength, i_readEnableMem, i_writeEnableMem,
           i_dataMem, i_byteEnableMem,
    input  o_busyMem, o_dataValidMem, o_dataMem, o_protocolError
  );

  modport slave (
    input  i_targetAddr, i_burstLength, i_readEnableMem, i_writeEnableMem,
           i_dataMem, i_byteEnableMem,
    output o_busyMem, o_dataValidMem, o_dataMem, o_protocolError
  );
endinterface

// File: rtl/psx_ddr_avalon_responder.sv
// DDR stand-in Avalon-MM slave: on-chip RAM with byte-enabled burst writes,
// a queue of pipelined burst reads with fixed latency, and optional
// pseudo-random waitrequest injection.
module psx_ddr_avalon_responder #(
  parameter int          ADDR_W        = 17,
  parameter int          READ_LATENCY  = 4,
  parameter int          RD_FIFO_DEPTH = 4,
  parameter int          STALL_EN      = 0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic i_clk,
  input logic i_rst,
  psx_ddr_avalon_responder_if.slave bus
);
  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int DL    = READ_LATENCY - 1;

  typedef enum logic [0:0] {IDLE = 1'b0, WR_BURST = 1'b1} state_t;

  logic [63:0] mem [2**ADDR_W];

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt, mem_waddr;
  logic [2:0]        wr_left, wr_left_nxt;
  logic              mem_we;

  logic [15:0] lfsr;
  logic        stall, busy, rd_req, wr_req, wr_acc, rd_acc, err_set, err;
  logic [2:0]  burst_n;

  logic [ADDR_W-1:0] fifo_addr [RD_FIFO_DEPTH];
  logic [2:0]        fifo_len  [RD_FIFO_DEPTH];
  logic [PTR_W:0]    wptr, rptr, outstanding;
  logic              fifo_empty, full;

  logic              eng_active, eng_active_nxt;
  logic [ADDR_W-1:0] eng_addr, eng_addr_nxt, rd_addr;
  logic [2:0]        eng_left, eng_left_nxt;
  logic              pop, issue, issue_last;

  logic [63:0]   dl_data [DL];
  logic [DL-1:0] dl_valid, dl_last;
  logic          retire, out_valid;
  logic [63:0]   out_data;

  assign rd_req     = bus.i_readEnableMem;
  assign wr_req     = bus.i_writeEnableMem;
  assign burst_n    = (bus.i_burstLength == 3'd0) ? 3'd1 : bus.i_burstLength;
  assign fifo_empty = (wptr == rptr);
  // "Full" counts commands until their last beat leaves the delay line, so
  // at most RD_FIFO_DEPTH reads are ever in flight.
  assign full       = (outstanding == (PTR_W+1)'(RD_FIFO_DEPTH));
  assign stall      = (STALL_EN != 0) && (lfsr[1:0] == 2'b00);
  // A write opening in IDLE waits for every outstanding read to be delivered.
  assign busy       = i_rst | stall | (rd_req & full)
                    | (wr_req & (state == IDLE) & (outstanding != '0));
  assign wr_acc     = wr_req & ~busy;
  assign rd_acc     = rd_req & ~wr_req & ~busy & (state == IDLE);
  assign err_set    = (rd_req & (state == WR_BURST))
                    | (rd_req & wr_req & ~busy & (state == IDLE));
  assign retire     = dl_valid[DL-1] & dl_last[DL-1];

  assign bus.o_busyMem       = busy;
  assign bus.o_dataValidMem  = out_valid;
  assign bus.o_dataMem       = out_data;
  assign bus.o_protocolError = err;

  // Write FSM next state, burst address/count and RAM write strobe.
  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    wr_left_nxt = wr_left;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    case (state)
      IDLE: begin
        if (wr_acc) begin
          mem_we      = 1'b1;
          mem_waddr   = bus.i_targetAddr;
          wr_addr_nxt = bus.i_targetAddr + ADDR_W'(1);
          wr_left_nxt = burst_n - 3'd1;
          state_nxt   = (burst_n != 3'd1) ? WR_BURST : IDLE;
        end else begin
          state_nxt = IDLE;
        end
      end
      WR_BURST: begin
        if (wr_acc) begin
          mem_we      = 1'b1;
          mem_waddr   = wr_addr;
          wr_addr_nxt = wr_addr + ADDR_W'(1);
          wr_left_nxt = wr_left - 3'd1;
          state_nxt   = (wr_left == 3'd1) ? IDLE : WR_BURST;
        end else begin
          state_nxt = WR_BURST;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write FSM state and burst bookkeeping registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      wr_addr <= '0;
      wr_left <= 3'd0;
    end else begin
      state   <= state_nxt;
      wr_addr <= wr_addr_nxt;
      wr_left <= wr_left_nxt;
    end
  end

  // Byte-enabled RAM write port (contents survive reset).
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (bus.i_byteEnableMem[k]) begin
          mem[mem_waddr][8*k +: 8] <= bus.i_dataMem[8*k +: 8];
        end
      end
    end
  end

  // Read engine: continue the current burst, else pop the next command.
  always_comb begin
    eng_active_nxt = eng_active;
    eng_addr_nxt   = eng_addr;
    eng_left_nxt   = eng_left;
    pop            = 1'b0;
    issue          = 1'b0;
    issue_last     = 1'b0;
    rd_addr        = eng_addr;
    if (eng_active) begin
      issue          = 1'b1;
      eng_addr_nxt   = eng_addr + ADDR_W'(1);
      eng_left_nxt   = eng_left - 3'd1;
      issue_last     = (eng_left == 3'd1);
      eng_active_nxt = (eng_left != 3'd1);
    end else if (!fifo_empty) begin
      pop            = 1'b1;
      issue          = 1'b1;
      rd_addr        = fifo_addr[rptr[PTR_W-1:0]];
      eng_addr_nxt   = fifo_addr[rptr[PTR_W-1:0]] + ADDR_W'(1);
      eng_left_nxt   = fifo_len[rptr[PTR_W-1:0]] - 3'd1;
      issue_last     = (fifo_len[rptr[PTR_W-1:0]] == 3'd1);
      eng_active_nxt = (fifo_len[rptr[PTR_W-1:0]] != 3'd1);
    end else begin
      eng_active_nxt = 1'b0;
    end
  end

  // Command FIFO storage (pointers carry the reset state).
  always_ff @(posedge i_clk) begin
    if (rd_acc) begin
      fifo_addr[wptr[PTR_W-1:0]] <= bus.i_targetAddr;
      fifo_len[wptr[PTR_W-1:0]]  <= burst_n;
    end
  end

  // FIFO pointers, in-flight count, engine registers and valid delay line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr        <= '0;
      rptr        <= '0;
      outstanding <= '0;
      eng_active  <= 1'b0;
      eng_addr    <= '0;
      eng_left    <= 3'd0;
      dl_valid    <= '0;
      dl_last     <= '0;
    end else begin
      if (rd_acc) wptr <= wptr + (PTR_W+1)'(1);
      if (pop)    rptr <= rptr + (PTR_W+1)'(1);
      case ({rd_acc, retire})
        2'b10:   outstanding <= outstanding + (PTR_W+1)'(1);
        2'b01:   outstanding <= outstanding - (PTR_W+1)'(1);
        default: outstanding <= outstanding;
      endcase
      eng_active  <= eng_active_nxt;
      eng_addr    <= eng_addr_nxt;
      eng_left    <= eng_left_nxt;
      dl_valid[0] <= issue;
      dl_last[0]  <= issue_last;
      for (int i = 1; i < DL; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_last[i]  <= dl_last[i-1];
      end
    end
  end

  // RAM read port feeding the data delay line.
  always_ff @(posedge i_clk) begin
    dl_data[0] <= mem[rd_addr];
    for (int i = 1; i < DL; i++) begin
      dl_data[i] <= dl_data[i-1];
    end
  end

  // Registered read-data outputs; data holds between valid beats.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid <= 1'b0;
      out_data  <= 64'd0;
    end else begin
      out_valid <= dl_valid[DL-1];
      if (dl_valid[DL-1]) out_data <= dl_data[DL-1];
    end
  end

  // Sticky protocol-error flag and free-running stall LFSR.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err  <= 1'b0;
      lfsr <= LFSR_SEED;
    end else begin
      if (err_set) err <= 1'b1;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
endmodule

// File: tb/tb_psx_ddr_avalon_responder.sv
// Directed self-checking bench for psx_ddr_avalon_responder.
module tb_psx_ddr_avalon_responder;
  logic clk;
  logic rst;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [63:0] rq[$];
  int rc[$];

  psx_ddr_avalon_responder_if #(.ADDR_W(17)) bus ();

  psx_ddr_avalon_responder #(
    .ADDR_W(17), .READ_LATENCY(4), .RD_FIFO_DEPTH(4),
    .STALL_EN(0), .LFSR_SEED(16'hACE1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every delivered read beat with the edge count it appeared at.
  always @(posedge clk) begin
    #1;
    if (bus.o_dataValidMem === 1'b1) begin
      rq.push_back(bus.o_dataMem);
      rc.push_back(cyc);
    end
  end

  task automatic bus_idle();
    bus.i_readEnableMem  = 1'b0;
    bus.i_writeEnableMem = 1'b0;
  endtask

  // Present a beat/command and hold it until accepted (bounded).
  task automatic bus_cmd(input logic rd, input logic wr, input logic [16:0] addr,
                         input logic [2:0] burst, input logic [63:0] data,
                         input logic [7:0] be, output bit ok, output int acc);
    ok = 1'b0;
    acc = -1;
    bus.i_readEnableMem  = rd;
    bus.i_writeEnableMem = wr;
    bus.i_targetAddr     = addr;
    bus.i_burstLength    = burst;
    bus.i_dataMem        = data;
    bus.i_byteEnableMem  = be;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.o_busyMem === 1'b0) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        acc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [16:0] addr, input logic [63:0] data,
                            input logic [7:0] be, output bit ok);
    int acc;
    bus_cmd(1'b0, 1'b1, addr, 3'd1, data, be, ok, acc);
    bus_idle();
  endtask

  task automatic read_word(input logic [16:0] addr, output logic [63:0] d,
                           output int n, output int lat);
    bit ok;
    int acc;
    rq.delete();
    rc.delete();
    bus_cmd(1'b1, 1'b0, addr, 3'd1, 64'd0, 8'h00, ok, acc);
    bus_idle();
    repeat (12) @(posedge clk);
    #1;
    n = ok ? rq.size() : -1;
    d = (rq.size() > 0) ? rq[0] : 64'hDEAD_DEAD_DEAD_DEAD;
    lat = (rc.size() > 0) ? rc[0] - acc : -1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.o_busyMem !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", bus.o_busyMem); end
    checks++; if (bus.o_dataValidMem !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.o_dataValidMem); end
    checks++; if (bus.o_dataMem !== 64'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus.o_dataMem); end
    checks++; if (bus.o_protocolError !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.o_protocolError); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.o_busyMem !== 1'b0) begin errors++; $display("FAIL release_busy got %b want 0", bus.o_busyMem); end
  endtask

  task automatic test_single();
    bit ok;
    logic [63:0] d;
    int n, lat;
    write_word(17'h00010, 64'h0123456789ABCDEF, 8'hFF, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_wr_accept got %b want 1", ok); end
    read_word(17'h00010, d, n, lat);
    checks++; if (n != 1) begin errors++; $display("FAIL single_beats got %0d want 1", n); end
    checks++; if (lat != 4) begin errors++; $display("FAIL single_latency got %0d want 4", lat); end
    checks++; if (d !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL single_data got %h want 0123456789abcdef", d); end
  endtask

  task automatic test_byte_enable();
    bit ok1, ok2;
    logic [63:0] d;
    int n, lat;
    write_word(17'h00040, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, ok1);
    write_word(17'h00040, 64'h0, 8'h0F, ok2);
    read_word(17'h00040, d, n, lat);
    checks++; if (d !== 64'hFFFF_FFFF_0000_0000 || n != 1) begin errors++; $display("FAIL be_merge got %h (beats %0d) want ffffffff00000000", d, n); end
  endtask

  task automatic test_pipelined();
    bit ok;
    int acc0, acc5;
    for (int i = 0; i < 4; i++) write_word(17'(i), 64'(10 + i), 8'hFF, ok);
    rq.delete();
    rc.delete();
    acc0 = 0;
    for (int i = 0; i < 4; i++) begin
      bus.i_readEnableMem  = 1'b1;
      bus.i_writeEnableMem = 1'b0;
      bus.i_targetAddr     = 17'(i);
      bus.i_burstLength    = 3'd1;
      @(negedge clk);
      checks++; if (bus.o_busyMem !== 1'b0) begin errors++; $display("FAIL pipe_accept%0d busy got %b want 0", i, bus.o_busyMem); end
      @(posedge clk);
      #1;
      if (i == 0) acc0 = cyc;
    end
    bus.i_targetAddr = 17'h00000;
    @(negedge clk);
    checks++; if (bus.o_busyMem !== 1'b1 || rq.size() != 0) begin errors++; $display("FAIL pipe_fifo_full busy got %b beats %0d want 1 and 0", bus.o_busyMem, rq.size()); end
    @(posedge clk);
    #1;
    bus_cmd(1'b1, 1'b0, 17'h00000, 3'd1, 64'd0, 8'h00, ok, acc5);
    bus_idle();
    checks++; if (acc5 != acc0 + 5) begin errors++; $display("FAIL pipe_fifth_accept got %0d want %0d", acc5 - acc0, 5); end
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (rq.size() != 5) begin
      errors++; $display("FAIL pipe_beats got %0d want 5", rq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rq[i] !== 64'(10 + i) || rc[i] != acc0 + 4 + i) begin errors++; $display("FAIL pipe_beat%0d got %h at +%0d want %h at +%0d", i, rq[i], rc[i] - acc0, 64'(10 + i), 4 + i); end
      end
      checks++; if (rq[4] !== 64'd10 || rc[4] != acc0 + 9) begin errors++; $display("FAIL pipe_beat4 got %h at +%0d want a at +9", rq[4], rc[4] - acc0); end
    end
  endtask

  task automatic test_burst_wrap();
    bit ok, all_ok;
    int acc;
    logic [63:0] d;
    int n, lat;
    bus_cmd(1'b0, 1'b1, 17'h1FFFE, 3'd4, 64'd1, 8'hFF, all_ok, acc);
    for (int b = 1; b < 4; b++) begin
      bus_cmd(1'b0, 1'b1, 17'h00123, 3'd0, 64'(b + 1), 8'hFF, ok, acc);
      all_ok = all_ok & ok;
    end
    bus_idle();
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL wrap_wr_accept got %b want 1", all_ok); end
    read_word(17'h1FFFF, d, n, lat);
    checks++; if (d !== 64'd2) begin errors++; $display("FAIL wrap_word_1ffff got %h want 2", d); end
    read_word(17'h00000, d, n, lat);
    checks++; if (d !== 64'd3) begin errors++; $display("FAIL wrap_word_00000 got %h want 3", d); end
    read_word(17'h00001, d, n, lat);
    checks++; if (d !== 64'd4) begin errors++; $display("FAIL wrap_word_00001 got %h want 4", d); end
    rq.delete();
    rc.delete();
    bus_cmd(1'b1, 1'b0, 17'h1FFFE, 3'd4, 64'd0, 8'h00, ok, acc);
    bus_idle();
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (rq.size() != 4) begin
      errors++; $display("FAIL wrap_rd_beats got %0d want 4", rq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rq[i] !== 64'(i + 1) || rc[i] != acc + 4 + i) begin errors++; $display("FAIL wrap_rd_beat%0d got %h at +%0d want %h at +%0d", i, rq[i], rc[i] - acc, 64'(i + 1), 4 + i); end
      end
    end
  endtask

  task automatic test_write_after_read();
    bit ok, okr, okw;
    int accr, accw, n, lat;
    logic [63:0] d;
    write_word(17'h00020, 64'hAAAA_5555_AAAA_5555, 8'hFF, ok);
    rq.delete();
    rc.delete();
    bus_cmd(1'b1, 1'b0, 17'h00020, 3'd1, 64'd0, 8'h00, okr, accr);
    bus_cmd(1'b0, 1'b1, 17'h00020, 3'd1, 64'd5, 8'hFF, okw, accw);
    bus_idle();
    repeat (12) @(posedge clk);
    #1;
    checks++; if (okw !== 1'b1 || accw != accr + 5) begin errors++; $display("FAIL war_write_wait got +%0d want +5", accw - accr); end
    checks++; if (rq.size() != 1 || rq[0] !== 64'hAAAA_5555_AAAA_5555) begin errors++; $display("FAIL war_old_data beats %0d want 1 with aaaa5555aaaa5555", rq.size()); end
    read_word(17'h00020, d, n, lat);
    checks++; if (d !== 64'd5) begin errors++; $display("FAIL war_new_data got %h want 5", d); end
  endtask

  task automatic test_errors();
    bit ok;
    int acc, n, lat;
    logic [63:0] d;
    checks++; if (bus.o_protocolError !== 1'b0) begin errors++; $display("FAIL err_initial got %b want 0", bus.o_protocolError); end
    rq.delete();
    rc.delete();
    bus_cmd(1'b1, 1'b1, 17'h00030, 3'd1, 64'h77, 8'hFF, ok, acc);
    bus_idle();
    repeat (12) @(posedge clk);
    #1;
    checks++; if (rq.size() != 0) begin errors++; $display("FAIL err_read_dropped got %0d beats want 0", rq.size()); end
    checks++; if (bus.o_protocolError !== 1'b1) begin errors++; $display("FAIL err_flag got %b want 1", bus.o_protocolError); end
    read_word(17'h00030, d, n, lat);
    checks++; if (d !== 64'h77) begin errors++; $display("FAIL err_write_done got %h want 77", d); end
    checks++; if (bus.o_protocolError !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus.o_protocolError); end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int acc;
    rq.delete();
    rc.delete();
    bus_cmd(1'b1, 1'b0, 17'h1FFFE, 3'd4, 64'd0, 8'h00, ok, acc);
    bus_idle();
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.o_dataValidMem !== 1'b0 || bus.o_busyMem !== 1'b1) begin errors++; $display("FAIL rstrd_outputs valid %b busy %b want 0 1", bus.o_dataValidMem, bus.o_busyMem); end
    checks++; if (bus.o_protocolError !== 1'b0 || bus.o_dataMem !== 64'd0) begin errors++; $display("FAIL rstrd_clear err %b data %h want 0 0", bus.o_protocolError, bus.o_dataMem); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rq.size() != 2) begin errors++; $display("FAIL rstrd_discard got %0d beats want 2", rq.size()); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int acc, n, lat;
    logic [63:0] d;
    bus_cmd(1'b0, 1'b1, 17'h00050, 3'd3, 64'h11, 8'hFF, ok, acc);
    bus_cmd(1'b0, 1'b1, 17'h00000, 3'd0, 64'h22, 8'hFF, ok, acc);
    #2;
    bus_idle();
    rst = 1'b1;
    #1;
    checks++; if (bus.o_busyMem !== 1'b1 || bus.o_dataValidMem !== 1'b0) begin errors++; $display("FAIL rstwr_outputs busy %b valid %b want 1 0", bus.o_busyMem, bus.o_dataValidMem); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    write_word(17'h00060, 64'h66, 8'hFF, ok);
    read_word(17'h00060, d, n, lat);
    checks++; if (d !== 64'h66) begin errors++; $display("FAIL rstwr_idle_after got %h want 66", d); end
    read_word(17'h00050, d, n, lat);
    checks++; if (d !== 64'h11) begin errors++; $display("FAIL rstwr_ram_kept0 got %h want 11", d); end
    read_word(17'h00051, d, n, lat);
    checks++; if (d !== 64'h22) begin errors++; $display("FAIL rstwr_ram_kept1 got %h want 22", d); end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_readEnableMem  = 1'b0;
    bus.i_writeEnableMem = 1'b0;
    bus.i_targetAddr     = 17'h0;
    bus.i_burstLength    = 3'd0;
    bus.i_dataMem        = 64'd0;
    bus.i_byteEnableMem  = 8'h00;
    test_reset();
    test_single();
    test_byte_enable();
    test_pipelined();
    test_burst_wrap();
    test_write_after_read();
    test_errors();
    test_reset_mid_read();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
